// File: rtl/xor_nibble_sequencer.sv
// Nibble-serial controller for a shared 4-bit XOR slice.
// Walks WIDTH-bit operands LSB nibble first and reports a zero flag.
module xor_nibble_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             ack,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic [3:0]       xa,
    output logic [3:0]       xb,
    input  logic [3:0]       xy
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [1:0] OP_XOR  = 2'b00;
    localparam logic [1:0] OP_INV  = 2'b01;
    localparam logic [1:0] OP_CMP  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [3:0]       acc_q, acc_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, zero_d;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [WIDTH-1:0] res_nxt;
    logic             last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_XOR;
            res_q   <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            zero_q  <= zero_d;
        end
    end

    // Nibble select and shadow-result merge; xy only matters in RUN.
    always_comb begin
        a_nib   = '0;
        b_nib   = '0;
        res_nxt = res_q;
        for (int i = 0; i < NIB; i++) begin
            if (idx_q == IW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
                res_nxt[4*i +: 4] = xy;
            end
        end
    end

    assign last = (idx_q == IW'(NIB - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        acc_d   = acc_q;
        y_d     = y_q;
        zero_d  = zero_q;
        xa      = 4'h0;
        xb      = 4'h0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (req) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    idx_d   = '0;
                    acc_d   = 4'h0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                xa = a_nib;
                unique case (op_q)
                    OP_INV:  xb = 4'hF;
                    OP_PASS: xb = 4'h0;
                    default: xb = b_nib;
                endcase
                res_d = res_nxt;
                acc_d = acc_q | xy;
                idx_d = idx_q + IW'(1);
                if (last) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                    zero_d  = ~|(acc_q | xy);
                    if (op_q != OP_CMP) begin
                        y_d = res_nxt;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_RUN);
    assign ack  = (state_q == S_DONE);
    assign y    = y_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_xor_nibble_sequencer.sv
// Scoreboard bench for xor_nibble_sequencer (8- and 16-bit builds).
// The XOR slice is modelled as a plain 4-bit xor.
module tb_xor_nibble_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int ecnt = 0;
    always @(posedge clk) ecnt++;

    logic        rst_n = 1'b0;

    logic        req8 = 1'b0;
    logic [1:0]  op8 = 2'b00;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, ack8, zero8;
    logic [7:0]  y8;
    logic [3:0]  xa8, xb8, xy8;

    logic        req16 = 1'b0;
    logic [1:0]  op16 = 2'b00;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, ack16, zero16;
    logic [15:0] y16;
    logic [3:0]  xa16, xb16, xy16;

    assign xy8  = xa8 ^ xb8;
    assign xy16 = xa16 ^ xb16;

    xor_nibble_sequencer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .req(req8), .op(op8),
        .a(a8), .b(b8), .busy(busy8), .ack(ack8), .y(y8),
        .zero(zero8), .xa(xa8), .xb(xb8), .xy(xy8)
    );

    xor_nibble_sequencer #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .req(req16), .op(op16),
        .a(a16), .b(b16), .busy(busy16), .ack(ack16), .y(y16),
        .zero(zero16), .xa(xa16), .xb(xb16), .xy(xy16)
    );

    typedef struct {
        logic [15:0] y;
        logic        z;
        int          cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon8
        exp_t e;
        if (rst_n && ack8) begin
            if (q8.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ack8_unexpected: got ack at edge %0d expected none", ecnt);
            end else begin
                e = q8.pop_front();
                chk("y8", 32'(y8), 32'(e.y));
                chk("zero8", 32'(zero8), 32'(e.z));
                chk("ack8_cycle", ecnt, e.cyc);
                chk("busy8_with_ack", 32'(busy8), 32'd0);
            end
        end
    end

    always @(negedge clk) begin : mon16
        exp_t e;
        if (rst_n && ack16) begin
            if (q16.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ack16_unexpected: got ack at edge %0d expected none", ecnt);
            end else begin
                e = q16.pop_front();
                chk("y16", 32'(y16), 32'(e.y));
                chk("zero16", 32'(zero16), 32'(e.z));
                chk("ack16_cycle", ecnt, e.cyc);
            end
        end
    end

    task automatic issue8(input logic [1:0] o, input logic [7:0] aa,
                          input logic [7:0] bb, input logic [7:0] ey,
                          input logic ez);
        exp_t e;
        @(posedge clk);
        #1;
        req8 = 1'b1;
        op8  = o;
        a8   = aa;
        b8   = bb;
        e.y   = 16'(ey);
        e.z   = ez;
        e.cyc = ecnt + 3;
        q8.push_back(e);
        @(posedge clk);
        #1;
        req8 = 1'b0;
    endtask

    task automatic drain8();
        for (int i = 0; i < 30 && q8.size() != 0; i++) @(posedge clk);
        if (q8.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain8: got %0d pending expected 0", q8.size());
            q8.delete();
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic drain16();
        for (int i = 0; i < 30 && q16.size() != 0; i++) @(posedge clk);
        if (q16.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain16: got %0d pending expected 0", q16.size());
            q16.delete();
        end
        repeat (4) @(posedge clk);
    endtask

    initial begin
        int   n;
        exp_t e;

        @(negedge clk);
        chk("rst_y8", 32'(y8), 32'h0);
        chk("rst_zero8", 32'(zero8), 32'h0);
        chk("rst_ack8", 32'(ack8), 32'h0);
        chk("rst_busy8", 32'(busy8), 32'h0);
        chk("rst_xa8", 32'(xa8), 32'h0);
        chk("rst_xb8", 32'(xb8), 32'h0);
        chk("rst_y16", 32'(y16), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // XOR 5A^FF, with per-nibble slice drive and busy window
        issue8(2'b00, 8'h5A, 8'hFF, 8'hA5, 1'b0);
        @(negedge clk);
        chk("t1_busy_c1", 32'(busy8), 32'd1);
        chk("t1_xa_lo", 32'(xa8), 32'hA);
        chk("t1_xb_lo", 32'(xb8), 32'hF);
        @(negedge clk);
        chk("t1_busy_c2", 32'(busy8), 32'd1);
        chk("t1_xa_hi", 32'(xa8), 32'h5);
        chk("t1_xb_hi", 32'(xb8), 32'hF);
        drain8();
        chk("t1_idle_busy", 32'(busy8), 32'd0);

        // CMP leaves y untouched
        issue8(2'b10, 8'h3C, 8'h3C, 8'hA5, 1'b1);
        drain8();
        issue8(2'b10, 8'h3C, 8'h3D, 8'hA5, 1'b0);
        drain8();

        // back-to-back with req held high
        @(posedge clk);
        #1;
        req8 = 1'b1;
        op8  = 2'b00;
        a8   = 8'h01;
        b8   = 8'h01;
        n    = ecnt;
        e.y = 16'h00; e.z = 1'b1; e.cyc = n + 3;
        q8.push_back(e);
        e.y = 16'hFF; e.z = 1'b0; e.cyc = n + 6;
        q8.push_back(e);
        @(posedge clk);
        #1;
        a8 = 8'hF0;
        b8 = 8'h0F;
        repeat (3) @(posedge clk);
        #1;
        req8 = 1'b0;
        drain8();

        // second req during RUN is ignored
        issue8(2'b00, 8'h5A, 8'hFF, 8'hA5, 1'b0);
        req8 = 1'b1;
        a8   = 8'h00;
        @(posedge clk);
        #1;
        req8 = 1'b0;
        drain8();

        // reset in cycle 2 of an op: immediate clear, no ack
        @(posedge clk);
        #1;
        req8 = 1'b1;
        op8  = 2'b00;
        a8   = 8'hFF;
        b8   = 8'h00;
        @(posedge clk);
        #1;
        req8 = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy8), 32'd0);
        chk("t6_ack", 32'(ack8), 32'd0);
        chk("t6_y", 32'(y8), 32'h0);
        chk("t6_xa", 32'(xa8), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drain8();

        // INV ignores b, PASS of zero sets the flag
        issue8(2'b01, 8'h0F, 8'h33, 8'hF0, 1'b0);
        @(negedge clk);
        chk("t2_inv_xb", 32'(xb8), 32'hF);
        drain8();
        issue8(2'b11, 8'h00, 8'h55, 8'h00, 1'b1);
        @(negedge clk);
        chk("t2_pass_xb", 32'(xb8), 32'h0);
        drain8();

        // 16-bit build: four nibbles, ack in cycle 5
        @(posedge clk);
        #1;
        req16 = 1'b1;
        op16  = 2'b00;
        a16   = 16'h1234;
        b16   = 16'hFFFF;
        e.y = 16'hEDCB; e.z = 1'b0; e.cyc = ecnt + 5;
        q16.push_back(e);
        @(posedge clk);
        #1;
        req16 = 1'b0;
        drain16();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
